img_frame_ctrl: RTL
===================

# img_frame_ctrl

Frame sequencer between the image/video timing generator and the filter/segmentation pipeline. On a software-style `start` pulse it arms on the next frame boundary, gates `img_de` through to the pipeline for a programmed number of complete frames, and tags each pixel with x/y coordinates. It reports frame progress, stops cleanly at a frame boundary on `stop`, and flags malformed frames.

## Interface
- `H_DISP`, 640, active pixels per line
- `V_DISP`, 480, active lines per frame
- `CNT_W`, 16, width of `pix_x`/`pix_y` counters
- `clk`  in  1  pixel clock
- `rst_n`  in  1  reset; asynchronous, active-low
- `start`  in  1  one-cycle request to begin a run; honoured only in IDLE
- `stop`  in  1  one-cycle request to end the run after the current frame
- `frame_num`  in  8  frames per run, sampled on accepted `start`; 0 = continuous
- `in_vsync`  in  1  frame sync from timing generator, active-low
- `in_de`  in  1  pixel valid from timing generator
- `out_de`  out  1  gated pixel valid to pipeline
- `pix_x`  out  CNT_W  column of pixel flagged by `out_de`
- `pix_y`  out  CNT_W  row of pixel flagged by `out_de`
- `frame_cnt`  out  8  completed frames in current run
- `busy`  out  1  high in any state except IDLE
- `done`  out  1  one-cycle pulse when run ends
- `err`  out  1  sticky malformed-frame flag (FRAME_CHECK_EN only)

## Operation
- Frame boundary: `vs_fall = vs_d & ~in_vsync`, with `vs_d` a registered copy of `in_vsync` that resets to 1.
- States: IDLE, ARM, RUN, FIN.
- IDLE: `start` → ARM; latch `frame_num`, clear `frame_cnt`, clear `stop_pend`, clear `err`. `stop` is ignored. If `start` and `stop` coincide, `start` is taken.
- ARM: wait for `vs_fall` → RUN with x = y = 0. `stop` in ARM → FIN directly, with `frame_cnt` unchanged.
- RUN: every `in_de` cycle drives `out_de` and increments x. On the falling edge of `in_de` (`de_d & ~in_de`), clear x and increment y.
- Frame completes on the `in_de` fall that ends line V_DISP-1. At completion, `frame_cnt` increments (wraps at 255).
  - Go to FIN if `stop_pend`, or if `frame_num != 0` and the new count equals `frame_num`.
  - Otherwise go to ARM.
- `stop` in RUN sets `stop_pend`. The current frame always completes.
- FIN: `done` = 1 for one cycle, then IDLE.
- `start` while busy is ignored.
- `in_de` outside RUN never produces `out_de`. Mid-line arming is impossible, because RUN is entered only at `vs_fall`.

## Timing
- Reset values: `out_de` = 0, `pix_x` = 0, `pix_y` = 0, `frame_cnt` = 0, `busy` = 0, `done` = 0, `err` = 0, state = IDLE.
- `busy` rises the cycle after the `start` edge.
- `out_de`, `pix_x` and `pix_y` are registered: 1-cycle latency from `in_de`, and the three are mutually aligned.
- `pix_x` counts 0..H_DISP-1 within each line. `pix_y` holds its value between lines.
- `frame_cnt` updates one cycle after the final `in_de` fall. `done` is asserted one cycle after that, and `busy` drops in the same cycle as `done`.
- Reset mid-frame: everything returns to reset values at once. The block then needs a new `start` plus `vs_fall`.

## Configuration
- `IMG_FRAME_CHECK_EN` defined:
  - `err` is set when a line ends with `pix_x + 1 != H_DISP`.
  - `err` is set when `vs_fall` occurs in RUN before frame completion. In that case the partial frame is abandoned: it is not counted, x and y clear, and the state stays RUN for the new frame.
  - `err` is sticky and is cleared only by an accepted `start` or by reset.
- Undefined:
  - `err` is tied to 0 and there is no line-length check.
  - `vs_fall` in RUN still restarts the frame silently, but nothing is flagged.

## Test plan
- Basic run: H_DISP = 8, V_DISP = 4, `frame_num` = 2, `start` pulse. Expect:
  - exactly 64 `out_de` cycles;
  - `pix_x` 0..7 and `pix_y` 0..3 per frame;
  - `frame_cnt` 1 then 2;
  - one `done` pulse, then `busy` = 0.
- Late arming: `start` mid-frame. Expect no `out_de` until after the next `vs_fall`, and the first tagged pixel has `pix_x` = 0, `pix_y` = 0.
- Continuous mode: `frame_num` = 0. Expect 5 frames to run; then `stop` at pixel 10 of frame 6 lets frame 6 finish, with `frame_cnt` = 6 and `done` once. `start` pulsed while busy is ignored.
- Edge cases: `start` and `stop` in the same IDLE cycle → run starts. `stop` in ARM → `done` with `frame_cnt` = 0 and no `out_de`.
- Reset: `rst_n` low mid-line → all outputs 0 immediately. With no new `start`, no `out_de` appears afterwards.
- Frame checks (`IMG_FRAME_CHECK_EN` defined):
  - a 7-pixel line → `err` = 1;
  - early `vs_fall` → `err` = 1 and the frame is not counted;
  - next `start` → `err` = 0.

Source files
------------

// File: rtl/img_frame_if.sv
// Pixel-stream interface between the video timing generator, img_frame_ctrl and the
// downstream filter/segmentation pipeline.
interface img_frame_if #(
    parameter int CNT_W = 16
) ();
    logic             in_vsync;
    logic             in_de;
    logic             out_de;
    logic [CNT_W-1:0] pix_x;
    logic [CNT_W-1:0] pix_y;

    // master: timing generator / pipeline side; slave: the frame controller
    modport master (output in_vsync, in_de, input out_de, pix_x, pix_y);
    modport slave  (input in_vsync, in_de, output out_de, pix_x, pix_y);
endinterface

// File: rtl/img_frame_ctrl.sv
// Frame sequencer: arms on vsync fall, gates in_de for a programmed number of frames
// and tags pixels with x/y. Define IMG_FRAME_CHECK_EN for the malformed-frame err flag.
module img_frame_ctrl #(
    parameter int H_DISP = 640,
    parameter int V_DISP = 480,
    parameter int CNT_W  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic [7:0] frame_num,
    img_frame_if.slave vid,
    output logic [7:0] frame_cnt,
    output logic       busy,
    output logic       done,
    output logic       err
);
    typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_FIN} state_e;

    if (H_DISP < 1 || V_DISP < 1 || H_DISP >= (1 << CNT_W) || V_DISP >= (1 << CNT_W))
    begin : g_bad_geometry
        $error("img_frame_ctrl: H_DISP/V_DISP do not fit in CNT_W");
    end

    state_e           state_q;
    logic             vs_d_q;
    logic             de_d_q;
    logic [CNT_W-1:0] x_q;
    logic [CNT_W-1:0] y_q;
    logic [CNT_W-1:0] pix_x_q;
    logic [CNT_W-1:0] pix_y_q;
    logic             out_de_q;
    logic             busy_q;
    logic             done_q;
    logic             stop_pend_q;
    logic [7:0]       frame_cnt_q;
    logic [7:0]       frame_num_q;

    logic             vs_fall;
    logic             de_fall;
    logic             last_line;
    logic             run_end;
    logic [7:0]       cnt_next;

    assign vs_fall   = vs_d_q & ~vid.in_vsync;
    assign de_fall   = de_d_q & ~vid.in_de;
    assign last_line = (y_q == CNT_W'(V_DISP - 1));
    assign cnt_next  = frame_cnt_q + 8'd1;
    // a stop arriving on the completing edge itself still ends the run
    assign run_end   = stop_pend_q | stop |
                       ((frame_num_q != 8'd0) && (cnt_next == frame_num_q));

`ifdef IMG_FRAME_CHECK_EN
    logic err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            vs_d_q      <= 1'b1;
            de_d_q      <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
            out_de_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            stop_pend_q <= 1'b0;
            frame_cnt_q <= 8'd0;
            frame_num_q <= 8'd0;
`ifdef IMG_FRAME_CHECK_EN
            err_q       <= 1'b0;
`endif
        end else begin
            vs_d_q   <= vid.in_vsync;
            de_d_q   <= vid.in_de;
            // NOTE: pulse outputs default low here; later non-blocking writes in the case win.
            out_de_q <= 1'b0;
            done_q   <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q     <= S_ARM;
                        busy_q      <= 1'b1;
                        frame_num_q <= frame_num;
                        frame_cnt_q <= 8'd0;
                        stop_pend_q <= 1'b0;
`ifdef IMG_FRAME_CHECK_EN
                        err_q       <= 1'b0;
`endif
                    end
                end

                S_ARM: begin
                    if (stop) begin
                        state_q <= S_FIN;
                    end else if (vs_fall) begin
                        state_q <= S_RUN;
                        x_q     <= '0;
                        y_q     <= '0;
                    end
                end

                S_RUN: begin
                    if (stop) stop_pend_q <= 1'b1;

                    if (vid.in_de) begin
                        out_de_q <= 1'b1;
                        pix_x_q  <= x_q;
                        pix_y_q  <= y_q;
                        x_q      <= x_q + CNT_W'(1);
                    end

                    if (de_fall) begin
                        x_q <= '0;
`ifdef IMG_FRAME_CHECK_EN
                        if (x_q != CNT_W'(H_DISP)) err_q <= 1'b1;
`endif
                        if (last_line) begin
                            y_q         <= '0;
                            frame_cnt_q <= cnt_next;
                            state_q     <= run_end ? S_FIN : S_ARM;
                        end else begin
                            y_q <= y_q + CNT_W'(1);
                        end
                    end else if (vs_fall) begin
                        // early frame start: drop the partial frame and restart at 0,0
                        x_q <= '0;
                        y_q <= '0;
`ifdef IMG_FRAME_CHECK_EN
                        err_q <= 1'b1;
`endif
                    end
                end

                S_FIN: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign vid.out_de = out_de_q;
    assign vid.pix_x  = pix_x_q;
    assign vid.pix_y  = pix_y_q;
    assign frame_cnt  = frame_cnt_q;
    assign busy       = busy_q;
    assign done       = done_q;
endmodule
